// File: rtl/ctrl_pipe_nstage.sv
// Control-bundle pipeline between decoder and datapath: per-stage stall/flush,
// ARM condition evaluation in stage 0 against a private NZCV register.
module ctrl_pipe_nstage #(
    parameter int              CW        = 16,
    parameter int              STAGES    = 3,
    parameter logic [CW-1:0]   KILL_MASK = 16'h0007
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CW-1:0]          ctrl_d,
    input  logic                   valid_d,
    input  logic [3:0]             cond_d,
    input  logic [1:0]             flagwrite_d,
    input  logic [3:0]             alu_flags_e,
    input  logic [STAGES-1:0]      stall,
    input  logic [STAGES-1:0]      flush,
    output logic [STAGES*CW-1:0]   ctrl_q,
    output logic [STAGES-1:0]      valid_q,
    output logic                   cond_pass_e,
    output logic [3:0]             flags_q,
    output logic                   carry_e
);

    logic [CW-1:0] ctrlReg [STAGES];
    logic [STAGES-1:0] validReg;
    logic [3:0] condE;
    logic [1:0] flagWriteE;
    logic [3:0] flagsReg;
    logic condMet;

    wire flagN = flagsReg[3];
    wire flagZ = flagsReg[2];
    wire flagC = flagsReg[1];
    wire flagV = flagsReg[0];

    always_comb begin
        condMet = 1'b0;
        case (condE)
            4'b0000: condMet = flagZ;
            4'b0001: condMet = !flagZ;
            4'b0010: condMet = flagC;
            4'b0011: condMet = !flagC;
            4'b0100: condMet = flagN;
            4'b0101: condMet = !flagN;
            4'b0110: condMet = flagV;
            4'b0111: condMet = !flagV;
            4'b1000: condMet = flagC & !flagZ;
            4'b1001: condMet = !flagC | flagZ;
            4'b1010: condMet = (flagN == flagV);
            4'b1011: condMet = (flagN != flagV);
            4'b1100: condMet = !flagZ & (flagN == flagV);
            4'b1101: condMet = flagZ | (flagN != flagV);
            default: condMet = 1'b1;
        endcase
    end

    assign cond_pass_e = validReg[0] & condMet;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                ctrlReg[i] <= '0;
            end
            validReg   <= '0;
            condE      <= '0;
            flagWriteE <= '0;
            flagsReg   <= '0;
        end else begin
            if (flush[0]) begin
                validReg[0] <= 1'b0;
                ctrlReg[0]  <= '0;
                condE       <= '0;
                flagWriteE  <= '0;
            end else if (!stall[0]) begin
                validReg[0] <= valid_d;
                ctrlReg[0]  <= ctrl_d;
                condE       <= cond_d;
                flagWriteE  <= flagwrite_d;
            end

            for (int i = 1; i < STAGES; i++) begin
                if (flush[i]) begin
                    validReg[i] <= 1'b0;
                    ctrlReg[i]  <= '0;
                end else if (stall[i]) begin
                    validReg[i] <= validReg[i];
                    ctrlReg[i]  <= ctrlReg[i];
                end else if (stall[i-1]) begin
                    validReg[i] <= 1'b0;
                    ctrlReg[i]  <= '0;
                end else if (i == 1 && !cond_pass_e) begin
                    // Failed condition: strip side-effecting bits, keep the slot valid.
                    validReg[i] <= validReg[i-1];
                    ctrlReg[i]  <= ctrlReg[i-1] & ~KILL_MASK;
                end else begin
                    validReg[i] <= validReg[i-1];
                    ctrlReg[i]  <= ctrlReg[i-1];
                end
            end

            if (!stall[0] && !flush[0] && cond_pass_e) begin
                if (flagWriteE[1]) flagsReg[3:2] <= alu_flags_e[3:2];
                if (flagWriteE[0]) flagsReg[1:0] <= alu_flags_e[1:0];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : gen_flat
        assign ctrl_q[g*CW +: CW] = ctrlReg[g];
    end

    assign valid_q = validReg;
    assign flags_q = flagsReg;
    assign carry_e = flagsReg[1];

endmodule

// File: tb/tb_ctrl_pipe_nstage.sv
// Self-checking bench for ctrl_pipe_nstage: directed scenarios plus random traffic
// compared each cycle against a behavioural pipeline model.
module tb_ctrl_pipe_nstage;
    localparam int CW = 16;
    localparam int STAGES = 3;
    localparam logic [CW-1:0] KILL = 16'h0007;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0] ctrl_d;
    logic valid_d;
    logic [3:0] cond_d;
    logic [1:0] flagwrite_d;
    logic [3:0] alu_flags_e;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic [STAGES*CW-1:0] ctrl_q;
    logic [STAGES-1:0] valid_q;
    logic cond_pass_e;
    logic [3:0] flags_q;
    logic carry_e;

    ctrl_pipe_nstage #(.CW(CW), .STAGES(STAGES), .KILL_MASK(KILL)) dut (
        .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d),
        .cond_d(cond_d), .flagwrite_d(flagwrite_d), .alu_flags_e(alu_flags_e),
        .stall(stall), .flush(flush), .ctrl_q(ctrl_q), .valid_q(valid_q),
        .cond_pass_e(cond_pass_e), .flags_q(flags_q), .carry_e(carry_e)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass = 0;
    bit checkEn = 0;

    // Model state
    logic [STAGES-1:0] mValid;
    logic [CW-1:0] mCtrl [STAGES];
    logic [3:0] mCond;
    logic [1:0] mFw;
    logic [3:0] mFlags;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Base predicate selected by cond[3:1]; cond[0] inverts it, 111x always passes.
    function automatic bit condOk(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic bit mPass();
        return mValid[0] && condOk(mCond, mFlags);
    endfunction

    function automatic logic [STAGES*CW-1:0] mCtrlFlat();
        logic [STAGES*CW-1:0] r;
        for (int i = 0; i < STAGES; i++) r[i*CW +: CW] = mCtrl[i];
        return r;
    endfunction

    task automatic modelStep();
        logic [STAGES-1:0] nV;
        logic [CW-1:0] nC [STAGES];
        bit pass;
        if (!reset) begin
            mValid = '0;
            for (int i = 0; i < STAGES; i++) mCtrl[i] = '0;
            mCond = '0; mFw = '0; mFlags = '0;
            return;
        end
        pass = mPass();
        nV = mValid;
        for (int i = 0; i < STAGES; i++) nC[i] = mCtrl[i];
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
                nV[i] = 1'b0; nC[i] = '0;
            end else if (stall[i]) begin
                // hold
            end else if (i > 0 && stall[i-1]) begin
                nV[i] = 1'b0; nC[i] = '0;
            end else if (i == 0) begin
                nV[0] = valid_d; nC[0] = ctrl_d;
            end else begin
                nV[i] = mValid[i-1];
                nC[i] = (i == 1 && !pass) ? (mCtrl[0] & ~KILL) : mCtrl[i-1];
            end
        end
        if (!stall[0] && !flush[0] && pass) begin
            if (mFw[1]) mFlags[3:2] = alu_flags_e[3:2];
            if (mFw[0]) mFlags[1:0] = alu_flags_e[1:0];
        end
        if (flush[0]) begin
            mCond = '0; mFw = '0;
        end else if (!stall[0]) begin
            mCond = cond_d; mFw = flagwrite_d;
        end
        mValid = nV;
        for (int i = 0; i < STAGES; i++) mCtrl[i] = nC[i];
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle();
        valid_d = 0; ctrl_d = '0; cond_d = 4'b1110; flagwrite_d = 2'b00;
        alu_flags_e = 4'b0000; stall = '0; flush = '0;
    endtask

    task automatic instr(input logic [CW-1:0] c, input logic [3:0] cd, input logic [1:0] fw);
        valid_d = 1; ctrl_d = c; cond_d = cd; flagwrite_d = fw;
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] mdl,
                       input logic [63:0] exp);
        check({name, "/dut"}, act, exp);
        check({name, "/model"}, mdl, exp);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("valid_q", valid_q, mValid);
            check("ctrl_q", ctrl_q, mCtrlFlat());
            check("cond_pass_e", cond_pass_e, mPass());
            check("flags_q", flags_q, mFlags);
            check("carry_e", carry_e, mFlags[1]);
        end
    end

    initial begin
        idle();
        reset = 0;
        cycle();
        checkEn = 1;
        cycle();
        lit("rst_valid", valid_q, mValid, 0);
        lit("rst_ctrl", ctrl_q, mCtrlFlat(), 0);
        lit("rst_flags", flags_q, mFlags, 0);
        lit("rst_carry", carry_e, mFlags[1], 0);
        lit("rst_pass", cond_pass_e, mPass(), 0);
        reset = 1;

        // Latency
        instr(16'hA5A5, 4'b1110, 2'b00);
        cycle();
        lit("lat_s0", ctrl_q[0 +: CW], mCtrl[0], 16'hA5A5);
        lit("lat_v1", valid_q, mValid, 3'b001);
        cycle();
        lit("lat_s1", ctrl_q[CW +: CW], mCtrl[1], 16'hA5A5);
        lit("lat_v2", valid_q, mValid, 3'b011);
        cycle();
        lit("lat_s2", ctrl_q[2*CW +: CW], mCtrl[2], 16'hA5A5);
        lit("lat_v3", valid_q, mValid, 3'b111);
        idle();
        repeat (3) cycle();

        // Conditional kill and flag timing
        instr(16'h0001, 4'b1110, 2'b11);
        cycle();
        instr(16'h00FF, 4'b0001, 2'b00);
        alu_flags_e = 4'b0100;
        cycle();
        lit("kill_flags", flags_q, mFlags, 4'b0100);
        lit("kill_pass", cond_pass_e, mPass(), 0);
        idle();
        cycle();
        lit("kill_s1", ctrl_q[CW +: CW], mCtrl[1], 16'h00F8);
        lit("kill_v1", valid_q[1], mValid[1], 1);
        repeat (3) cycle();

        // Stall bubble
        instr(16'h1234, 4'b1110, 2'b00);
        cycle();
        idle();
        stall = 3'b001;
        for (int k = 0; k < 2; k++) begin
            cycle();
            lit("stall_s0", ctrl_q[0 +: CW], mCtrl[0], 16'h1234);
            lit("stall_v0", valid_q[0], mValid[0], 1);
            lit("stall_s1", ctrl_q[CW +: CW], mCtrl[1], 0);
            lit("stall_v1", valid_q[1], mValid[1], 0);
        end
        stall = '0;
        cycle();
        lit("stall_arr", ctrl_q[CW +: CW], mCtrl[1], 16'h1234);
        lit("stall_arrv", valid_q[1], mValid[1], 1);

        // Flush beats stall
        flush = 3'b010; stall = 3'b010;
        cycle();
        lit("flush_s1", ctrl_q[CW +: CW], mCtrl[1], 0);
        lit("flush_v1", valid_q[1], mValid[1], 0);
        idle();

        // Partial flag write
        reset = 0;
        cycle();
        reset = 1;
        instr(16'h0010, 4'b1110, 2'b01);
        cycle();
        instr(16'h0020, 4'b0100, 2'b00);
        alu_flags_e = 4'b1111;
        cycle();
        lit("pfw_flags", flags_q, mFlags, 4'b0011);
        lit("pfw_carry", carry_e, mFlags[1], 1);
        lit("pfw_mi", cond_pass_e, mPass(), 0);
        idle();
        repeat (2) cycle();

        // Reset mid-operation
        instr(16'h0F0F, 4'b1110, 2'b11);
        cycle();
        instr(16'h0F0F, 4'b1110, 2'b00);
        alu_flags_e = 4'b1010;
        cycle();
        cycle();
        lit("mid_flags", flags_q, mFlags, 4'b1010);
        lit("mid_full", valid_q, mValid, 3'b111);
        reset = 0; stall = 3'b111;
        cycle();
        lit("mid_valid", valid_q, mValid, 0);
        lit("mid_ctrl", ctrl_q, mCtrlFlat(), 0);
        lit("mid_flags0", flags_q, mFlags, 0);
        reset = 1; stall = '0;
        instr(16'hBEEF, 4'b1110, 2'b00);
        cycle();
        lit("resume_v", valid_q, mValid, 3'b001);
        lit("resume_s0", ctrl_q[0 +: CW], mCtrl[0], 16'hBEEF);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) != 0);
            valid_d = ($urandom_range(0, 3) != 0);
            ctrl_d = CW'($urandom);
            cond_d = 4'($urandom);
            flagwrite_d = 2'($urandom);
            alu_flags_e = 4'($urandom);
            for (int s = 0; s < STAGES; s++) begin
                stall[s] = ($urandom_range(0, 4) == 0);
                flush[s] = ($urandom_range(0, 7) == 0);
            end
            cycle();
        end
        idle();
        cycle();
        @(negedge clk);
        checkEn = 0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
